// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// State encoding, default operand width and step-counter sizing.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold the step count WIDTH down to 1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divisor_seq_subtrator_passo.sv
// Combinational WIDTH+1-bit trial subtraction a + ~b + 1, zero latency.
// No state and no backpressure; the difference MSB gives the sign.
module subtrator_passo #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           non_neg
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  assign diff    = a + ~b + ONE;
  assign non_neg = ~diff[WIDTH];

endmodule

// File: rtl/divisor_seq.sv
// Unsigned restoring divider, one quotient bit per clock; done WIDTH+1 cycles after start (1 for x/0).
// start is accepted only while ready is high; a start during RUN is dropped.
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign accept    = start & ready;
  assign last_step = (state == RUN) && (cnt == CNT_LAST);
  assign shifted   = {r[WIDTH-1:0], q[WIDTH-1]};

  subtrator_passo #(.WIDTH(WIDTH)) u_sub (
    .a       (shifted),
    .b       ({1'b0, d}),
    .diff    (trial),
    .non_neg (trial_ok)
  );

  // Restore by keeping the shifted value when the trial went negative.
  always_comb begin
    r_nxt = shifted;
    q_nxt = {q[WIDTH-2:0], 1'b0};
    if (trial_ok) begin
      r_nxt = trial;
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:        if (cnt == CNT_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        d   <= divisor;
        q   <= dividend;
        r   <= '0;
        cnt <= CNT_LOAD;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end
      end else if (state == RUN) begin
        r   <= r_nxt;
        q   <= q_nxt;
        cnt <= cnt - CNT_LAST;
        if (last_step) begin
          quotient    <= q_nxt;
          remainder   <= r_nxt[WIDTH-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end
    end
  end

  // The partial remainder never exceeds the divisor, so its top bit stays clear.
  always_ff @(posedge clk) begin
    if (!rst && state == RUN) assert (r[WIDTH] == 1'b0);
  end

endmodule

// File: tb/tb_divisor_seq.sv
// Randomised and directed bench for divisor_seq against a plain / and % reference.
module tb_divisor_seq;

  localparam int W = 8;
  localparam int LIMIT = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  divisor_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: {quotient, remainder, div_by_zero} from plain arithmetic.
  function automatic logic [2*W:0] model(input int a, input int b);
    logic [W-1:0] mq, mr;
    if (b == 0) return {{W{1'b1}}, W'(a), 1'b1};
    mq = W'(a / b);
    mr = W'(a % b);
    return {mq, mr, 1'b0};
  endfunction

  function automatic int model_latency(input int b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  task automatic launch(input int a, input int b);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the start-accept edge; stops at LIMIT if done never shows.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      fails++;
      $display("FAIL reset: rdy=%b done=%b q=%0d r=%0d dz=%b, want 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic;
    int cyc;
    launch(200, 7);
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy: ready=%b, want 0", ready);
    end
    wait_done(cyc);
    tests++;
    if (cyc !== 9) begin
      fails++;
      $display("FAIL basic_latency: %0d cycles, want 9", cyc);
    end
    tests++;
    if ({quotient, remainder, div_by_zero} !== model(200, 7)) begin
      fails++;
      $display("FAIL basic_result: q=%0d r=%0d dz=%b, want q=28 r=4 dz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    tests++;
    if ({done, ready, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 8'd28, 8'd4, 1'b0}) begin
      fails++;
      $display("FAIL basic_hold: done=%b rdy=%b q=%0d r=%0d, want 0 1 28 4", done, ready, quotient, remainder);
    end
  endtask

  task automatic test_boundaries;
    int a_tab[3] = '{255, 5, 255};
    int b_tab[3] = '{1, 9, 255};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      launch(a_tab[i], b_tab[i]);
      wait_done(cyc);
      tests++;
      if (cyc !== W + 1 || {quotient, remainder, div_by_zero} !== model(a_tab[i], b_tab[i])) begin
        fails++;
        $display("FAIL boundary %0d/%0d: lat=%0d q=%0d r=%0d, want lat=%0d q=%0d r=%0d",
                 a_tab[i], b_tab[i], cyc, quotient, remainder, W + 1,
                 a_tab[i] / b_tab[i], a_tab[i] % b_tab[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc;
    launch(37, 0);
    wait_done(cyc);
    tests++;
    if (cyc !== 1) begin
      fails++;
      $display("FAIL divzero_latency: %0d cycles, want 1", cyc);
    end
    tests++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd37, 1'b1}) begin
      fails++;
      $display("FAIL divzero_result: q=%0d r=%0d dz=%b, want 255 37 1", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(100, 3);
    cyc = 1;
    // Second request arrives mid-RUN and must be dropped.
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc !== 9 || {quotient, remainder, div_by_zero} !== {8'd33, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d, want lat=9 q=33 r=1", cyc, quotient, remainder);
    end
    // Relaunch on the done cycle itself.
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL done_ready: ready=%b, want 1", ready);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({ready, quotient, remainder} !== {1'b0, 8'd33, 8'd1}) begin
      fails++;
      $display("FAIL relaunch_hold: rdy=%b q=%0d r=%0d, want 0 33 1", ready, quotient, remainder);
    end
    wait_done(cyc);
    tests++;
    if (cyc !== 9 || {quotient, remainder, div_by_zero} !== model(50, 5)) begin
      fails++;
      $display("FAIL back_to_back: lat=%0d q=%0d r=%0d, want lat=9 q=10 r=0", cyc, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit seen;
    launch(200, 7);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    tests++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: rdy=%b done=%b q=%0d r=%0d dz=%b, want 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_nodone: done pulsed=%b, want 0", seen);
    end
    launch(9, 2);
    wait_done(cyc);
    tests++;
    if (cyc !== 9 || {quotient, remainder, div_by_zero} !== {8'd4, 8'd1, 1'b0}) begin
      fails++;
      $display("FAIL after_reset: lat=%0d q=%0d r=%0d, want lat=9 q=4 r=1", cyc, quotient, remainder);
    end
  endtask

  task automatic test_random;
    int a, b, cyc;
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      launch(a, b);
      wait_done(cyc);
      tests++;
      if (cyc !== model_latency(b) || {quotient, remainder, div_by_zero} !== model(a, b)) begin
        fails++;
        $display("FAIL random %0d/%0d: lat=%0d q=%0d r=%0d dz=%b, want lat=%0d {q,r,dz}=%h",
                 a, b, cyc, quotient, remainder, div_by_zero, model_latency(b), model(a, b));
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Sequential unsigned restoring divider, one quotient bit per clock.
- Each step is a trial subtraction (a + ~b + 1) of the kind the somador block computes in subtract mode.
- Sits beside somador in the arithmetic unit and supplies quotient/remainder results.
- Uses a start/ready/done handshake, so a control FSM can launch a division and wait for completion.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  launch request; sampled only when ready=1.
- dividend  input  WIDTH  unsigned dividend; captured on accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on accepted start.
- ready  output  1  high in IDLE and DONE; block accepts start.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result, held stable until next accepted start.
- remainder  output  WIDTH  result, held stable until next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
- Internal registers:
  - R: partial remainder, WIDTH+1 bits.
  - Q: quotient/dividend shift register, WIDTH bits.
  - D: captured divisor, WIDTH bits.
  - cnt: step counter, ceil(log2(WIDTH+1)) bits.
- State IDLE:
  - ready=1.
  - On start=1: capture D=divisor, Q=dividend, R=0, cnt=WIDTH, clear div_by_zero, go to RUN.
  - If divisor=0: go directly to DONE instead.
- State RUN, one step per cycle:
  - Form T = {R[WIDTH-1:0], Q[WIDTH-1]} - {0, D}, WIDTH+1 bits.
  - If T is non-negative (MSB 0): R<=T and Q<={Q[WIDTH-2:0],1}.
  - Otherwise: R<={R[WIDTH-1:0],Q[WIDTH-1]} and Q<={Q[WIDTH-2:0],0}.
  - cnt decrements each step. On the step where cnt=1, go to DONE.
  - ready=0 throughout RUN; start is ignored.
- Entering DONE (registered on the transition):
  - quotient<=Q and remainder<=R[WIDTH-1:0].
  - done=1 for exactly the first DONE cycle.
  - DONE is then held with ready=1.
- Divide by zero (captured divisor=0):
  - RUN is skipped.
  - Next cycle: quotient=all ones, remainder=dividend, div_by_zero=1, done pulse.
- Latency:
  - Normal case: start-accept edge to done high = WIDTH+1 cycles (8-bit: 9 cycles).
  - Divide by zero: 1 cycle.
- State DONE:
  - Outputs hold.
  - start=1 relaunches exactly as from IDLE; the previous results stay visible until the new done.
  - With no start, remains in DONE.
  - done deasserts after its single cycle.
- Back-to-back: start on the done cycle itself is accepted (ready=1 then).
- Reset mid-operation: any state, rst=1 returns all outputs to reset values at the next edge. The in-flight division is discarded with no done.
- Simultaneous start and rst: rst wins.
- Arithmetic: the trial subtract is one extra bit wide, so no overflow. Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Decomposition:
- Shared package (divisor_pkg):
  - State enum: IDLE, RUN, DONE.
  - Default WIDTH constant.
  - Counter-width function.
- One sub-module, subtrator_passo:
  - Combinational WIDTH+1-bit trial subtraction (a + ~b + 1).
  - Outputs the difference and a non-negative flag.
  - Keeps the datapath aligned with the somador subtract path.
  - FSM and registers stay in divisor_seq.

Test Plan:
- Reset check: rst for 2 cycles -> ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
- Basic division: dividend=200, divisor=7, start one cycle -> done exactly 9 cycles later; quotient=28, remainder=4, div_by_zero=0; values held after done drops.
- Boundaries:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/255 -> quotient=1, remainder=0.
- Divide by zero: 37/0 -> done 1 cycle after start; quotient=255, remainder=37, div_by_zero=1.
- Start ignored while busy: 100/3 launched, then start with 50/5 during RUN (ignored); then 50/5 issued on the done cycle -> first result 33 r1, second accepted immediately, 10 r0 nine cycles later.
- Reset mid-operation: rst at cycle 4 of RUN -> no done pulse; outputs zero. A subsequent 9/2 gives 4 r1.
